// File: rtl/ace_txn_req_capture.sv
// Request capture for the slave-side transaction allocator: 2-entry AR/AW FIFO, one allocation
// in flight, descriptor write on grant. Optional allocation timeout: ACE_TXN_REQ_TIMEOUT_EN.
module ace_txn_req_capture #(
  parameter int ADDR_WIDTH     = 64,
  parameter int DATA_WIDTH     = 128,
  parameter int RAM_SIZE       = 16384,
  parameter int MAX_DESC       = 16,
  parameter int ID_WIDTH       = 16,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int OFFSET_W      = $clog2((RAM_SIZE * 8) / DATA_WIDTH),
  localparam int IDX_W         = $clog2(MAX_DESC)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  s_axvalid,
  output logic                  s_axready,
  input  logic [ADDR_WIDTH-1:0] s_axaddr,
  input  logic [7:0]            s_axlen,
  input  logic [ID_WIDTH-1:0]   s_axid,
  input  logic [2:0]            s_axsize,
  input  logic [1:0]            s_axburst,
  input  logic [3:0]            s_axsnoop,
  input  logic [MAX_DESC-1:0]   desc_avail,
  output logic                  txn_valid,
  output logic [7:0]            txn_size,
  input  logic                  alc_valid,
  input  logic [IDX_W-1:0]      alc_idx,
  input  logic [OFFSET_W-1:0]   alc_offset,
  output logic                  desc_wr_en,
  output logic [IDX_W-1:0]      desc_wr_idx,
  output logic [ADDR_WIDTH-1:0] desc_wr_addr,
  output logic [7:0]            desc_wr_len,
  output logic [ID_WIDTH-1:0]   desc_wr_id,
  output logic [8:0]            desc_wr_attr,
  output logic [OFFSET_W-1:0]   desc_wr_offset,
  output logic                  alc_timeout
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            len;
    logic [ID_WIDTH-1:0]   id;
    logic [8:0]            attr;
  } req_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WRITE} state_t;

  req_t                  fifo_q [2];
  req_t                  fifo_d [2];
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  rdy_en_q;
  state_t                state_q, state_d;
  logic                  txn_valid_q, txn_valid_d;
  logic [7:0]            txn_size_q, txn_size_d;
  logic                  desc_wr_en_q, desc_wr_en_d;
  logic [IDX_W-1:0]      desc_wr_idx_q, desc_wr_idx_d;
  logic [ADDR_WIDTH-1:0] desc_wr_addr_q, desc_wr_addr_d;
  logic [7:0]            desc_wr_len_q, desc_wr_len_d;
  logic [ID_WIDTH-1:0]   desc_wr_id_q, desc_wr_id_d;
  logic [8:0]            desc_wr_attr_q, desc_wr_attr_d;
  logic [OFFSET_W-1:0]   desc_wr_offset_q, desc_wr_offset_d;
  logic                  push, pop;
  req_t                  head, in_req;

`ifdef ACE_TXN_REQ_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             timeout_q, timeout_d;
  logic             expired;
  // True on the TIMEOUT_CYCLES-th WAIT cycle.
  assign expired     = (tmr_q == TMR_W'(TIMEOUT_CYCLES - 1));
  assign alc_timeout = timeout_q;
`else
  assign alc_timeout = 1'b0;
`endif

  // Ready comes only from registered count, and stays low until the first cycle after reset.
  assign s_axready = rdy_en_q & (cnt_q != 2'd2);
  assign push      = s_axvalid & s_axready;
  assign pop       = (state_q == WRITE);
  assign head      = fifo_q[rd_ptr_q];
  assign in_req    = '{addr: s_axaddr, len: s_axlen, id: s_axid,
                       attr: {s_axsize, s_axburst, s_axsnoop}};

  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      fifo_d[wr_ptr_q] = in_req;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    state_d          = state_q;
    txn_valid_d      = 1'b0;
    txn_size_d       = txn_size_q;
    desc_wr_en_d     = 1'b0;
    desc_wr_idx_d    = desc_wr_idx_q;
    desc_wr_addr_d   = desc_wr_addr_q;
    desc_wr_len_d    = desc_wr_len_q;
    desc_wr_id_d     = desc_wr_id_q;
    desc_wr_attr_d   = desc_wr_attr_q;
    desc_wr_offset_d = desc_wr_offset_q;
`ifdef ACE_TXN_REQ_TIMEOUT_EN
    tmr_d            = tmr_q;
    timeout_d        = timeout_q;
`endif
    case (state_q)
      IDLE: begin
        if ((cnt_q != 2'd0) && (|desc_avail)) begin
          state_d     = ISSUE;
          txn_valid_d = 1'b1;
          txn_size_d  = head.len;
        end
      end
      ISSUE: begin
        state_d = WAIT;
`ifdef ACE_TXN_REQ_TIMEOUT_EN
        tmr_d   = '0;
`endif
      end
      WAIT: begin
        // Outputs are registered, so the write is loaded here and shows during WRITE.
        if (alc_valid) begin
          state_d          = WRITE;
          desc_wr_en_d     = 1'b1;
          desc_wr_idx_d    = alc_idx;
          desc_wr_offset_d = alc_offset;
          desc_wr_addr_d   = head.addr;
          desc_wr_len_d    = head.len;
          desc_wr_id_d     = head.id;
          desc_wr_attr_d   = head.attr;
        end
`ifdef ACE_TXN_REQ_TIMEOUT_EN
        else if (expired) begin
          state_d     = ISSUE;
          txn_valid_d = 1'b1;
          txn_size_d  = head.len;
          timeout_d   = 1'b1;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
`endif
      end
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fifo_q[0]        <= '0;
      fifo_q[1]        <= '0;
      wr_ptr_q         <= 1'b0;
      rd_ptr_q         <= 1'b0;
      cnt_q            <= 2'd0;
      rdy_en_q         <= 1'b0;
      state_q          <= IDLE;
      txn_valid_q      <= 1'b0;
      txn_size_q       <= '0;
      desc_wr_en_q     <= 1'b0;
      desc_wr_idx_q    <= '0;
      desc_wr_addr_q   <= '0;
      desc_wr_len_q    <= '0;
      desc_wr_id_q     <= '0;
      desc_wr_attr_q   <= '0;
      desc_wr_offset_q <= '0;
`ifdef ACE_TXN_REQ_TIMEOUT_EN
      tmr_q            <= '0;
      timeout_q        <= 1'b0;
`endif
    end else begin
      fifo_q           <= fifo_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      cnt_q            <= cnt_d;
      rdy_en_q         <= 1'b1;
      state_q          <= state_d;
      txn_valid_q      <= txn_valid_d;
      txn_size_q       <= txn_size_d;
      desc_wr_en_q     <= desc_wr_en_d;
      desc_wr_idx_q    <= desc_wr_idx_d;
      desc_wr_addr_q   <= desc_wr_addr_d;
      desc_wr_len_q    <= desc_wr_len_d;
      desc_wr_id_q     <= desc_wr_id_d;
      desc_wr_attr_q   <= desc_wr_attr_d;
      desc_wr_offset_q <= desc_wr_offset_d;
`ifdef ACE_TXN_REQ_TIMEOUT_EN
      tmr_q            <= tmr_d;
      timeout_q        <= timeout_d;
`endif
    end
  end

  assign txn_valid      = txn_valid_q;
  assign txn_size       = txn_size_q;
  assign desc_wr_en     = desc_wr_en_q;
  assign desc_wr_idx    = desc_wr_idx_q;
  assign desc_wr_addr   = desc_wr_addr_q;
  assign desc_wr_len    = desc_wr_len_q;
  assign desc_wr_id     = desc_wr_id_q;
  assign desc_wr_attr   = desc_wr_attr_q;
  assign desc_wr_offset = desc_wr_offset_q;

endmodule

// File: tb/tb_ace_txn_req_capture.sv
// Scoreboard bench for ace_txn_req_capture: accepted requests and granted allocations are queued
// and matched against every txn_valid / desc_wr_en the DUT produces.
`timescale 1ns/1ps
module tb_ace_txn_req_capture;
  localparam int IDX_W = 4;
  localparam int OFFSET_W = 10;

  logic clk, resetn;
  logic s_axvalid, s_axready;
  logic [63:0] s_axaddr;
  logic [7:0] s_axlen;
  logic [15:0] s_axid;
  logic [2:0] s_axsize;
  logic [1:0] s_axburst;
  logic [3:0] s_axsnoop;
  logic [15:0] desc_avail;
  logic txn_valid;
  logic [7:0] txn_size;
  logic alc_valid;
  logic [IDX_W-1:0] alc_idx;
  logic [OFFSET_W-1:0] alc_offset;
  logic desc_wr_en;
  logic [IDX_W-1:0] desc_wr_idx;
  logic [63:0] desc_wr_addr;
  logic [7:0] desc_wr_len;
  logic [15:0] desc_wr_id;
  logic [8:0] desc_wr_attr;
  logic [OFFSET_W-1:0] desc_wr_offset;
  logic alc_timeout;

  ace_txn_req_capture #(
    .ADDR_WIDTH(64), .DATA_WIDTH(128), .RAM_SIZE(16384), .MAX_DESC(16),
    .ID_WIDTH(16), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .resetn(resetn),
    .s_axvalid(s_axvalid), .s_axready(s_axready), .s_axaddr(s_axaddr), .s_axlen(s_axlen),
    .s_axid(s_axid), .s_axsize(s_axsize), .s_axburst(s_axburst), .s_axsnoop(s_axsnoop),
    .desc_avail(desc_avail), .txn_valid(txn_valid), .txn_size(txn_size),
    .alc_valid(alc_valid), .alc_idx(alc_idx), .alc_offset(alc_offset),
    .desc_wr_en(desc_wr_en), .desc_wr_idx(desc_wr_idx), .desc_wr_addr(desc_wr_addr),
    .desc_wr_len(desc_wr_len), .desc_wr_id(desc_wr_id), .desc_wr_attr(desc_wr_attr),
    .desc_wr_offset(desc_wr_offset), .alc_timeout(alc_timeout)
  );

  typedef struct {
    logic [63:0] addr;
    logic [7:0]  len;
    logic [15:0] id;
    logic [8:0]  attr;
  } req_t;
  typedef struct {
    logic [IDX_W-1:0]    idx;
    logic [OFFSET_W-1:0] off;
  } alc_t;

  req_t exp_q[$];
  alc_t alc_q[$];
  req_t mon_r;
  alc_t mon_a;
  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  // Scoreboard monitor: every allocation request and descriptor write must match the queue heads.
  always @(negedge clk) begin
    if (resetn) begin
      if (txn_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL txn_unexpected: txn_valid=1 with no queued request");
        end else if (txn_size !== exp_q[0].len) begin
          errors++;
          $display("FAIL txn_size: got %0d expected %0d", txn_size, exp_q[0].len);
        end
      end
      if (desc_wr_en) begin
        checks++;
        if (exp_q.size() == 0 || alc_q.size() == 0) begin
          errors++;
          $display("FAIL desc_wr_unexpected: desc_wr_en=1 id=%0h with nothing expected", desc_wr_id);
        end else begin
          mon_r = exp_q.pop_front();
          mon_a = alc_q.pop_front();
          if (desc_wr_addr !== mon_r.addr || desc_wr_len !== mon_r.len || desc_wr_id !== mon_r.id ||
              desc_wr_attr !== mon_r.attr || desc_wr_idx !== mon_a.idx || desc_wr_offset !== mon_a.off) begin
            errors++;
            $display("FAIL desc_wr_fields: got addr=%0h len=%0d id=%0h attr=%0h idx=%0d off=%0h expected addr=%0h len=%0d id=%0h attr=%0h idx=%0d off=%0h",
                     desc_wr_addr, desc_wr_len, desc_wr_id, desc_wr_attr, desc_wr_idx, desc_wr_offset,
                     mon_r.addr, mon_r.len, mon_r.id, mon_r.attr, mon_a.idx, mon_a.off);
          end
        end
      end
    end
  end

  // Leaves s_axvalid high on return; caller is one ns after the accepting edge.
  task automatic send_req(input logic [63:0] addr, input logic [7:0] len, input logic [15:0] id,
                          input logic [8:0] attr);
    req_t r;
    bit hs;
    bit ok;
    r.addr = addr; r.len = len; r.id = id; r.attr = attr;
    s_axaddr = addr; s_axlen = len; s_axid = id;
    {s_axsize, s_axburst, s_axsnoop} = attr;
    s_axvalid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      hs = s_axready;
      @(posedge clk); #1;
      if (hs) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (ok) exp_q.push_back(r);
    else begin
      errors++;
      $display("FAIL req_accept: id=%0h not accepted within 100 cycles", id);
    end
  endtask

  task automatic wait_txn(input int bound, output int cyc);
    cyc = -1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (txn_valid) begin
        cyc = i;
        break;
      end
    end
    checks++;
    if (cyc < 0) begin
      errors++;
      $display("FAIL txn_wait: no txn_valid within %0d cycles", bound);
    end
  endtask

  // Called at the negedge of the txn_valid cycle; grants dly cycles later.
  task automatic give_alc(input logic [IDX_W-1:0] idx, input logic [OFFSET_W-1:0] off, input int dly);
    alc_t a;
    a.idx = idx; a.off = off;
    for (int i = 0; i < dly; i++) begin
      @(posedge clk); #1;
    end
    alc_valid = 1'b1; alc_idx = idx; alc_offset = off;
    alc_q.push_back(a);
    @(posedge clk); #1;
    alc_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (desc_wr_en !== 1'b1) begin
      errors++;
      $display("FAIL desc_wr_latency: desc_wr_en=%b one cycle after alc_valid, expected 1", desc_wr_en);
    end
  endtask

  task automatic check_drained(input string name);
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || alc_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d requests / %0d grants still pending, expected 0", name, exp_q.size(), alc_q.size());
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; s_axvalid = 1'b0; s_axaddr = '0; s_axlen = '0; s_axid = '0;
    s_axsize = '0; s_axburst = '0; s_axsnoop = '0; desc_avail = 16'hFFFF;
    alc_valid = 1'b0; alc_idx = '0; alc_offset = '0;
    #12;
    checks++;
    if ({s_axready, txn_valid, txn_size, desc_wr_en, desc_wr_idx, desc_wr_addr, desc_wr_len,
         desc_wr_id, desc_wr_attr, desc_wr_offset, alc_timeout} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: rdy=%b txn=%b size=%0d wr=%b addr=%0h expected all 0",
               s_axready, txn_valid, txn_size, desc_wr_en, desc_wr_addr);
    end
    @(negedge clk); resetn = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (s_axready !== 1'b1 || txn_valid !== 1'b0 || desc_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: rdy=%b txn=%b wr=%b expected 1 0 0", s_axready, txn_valid, desc_wr_en);
    end
  endtask

  task automatic test_single();
    int c;
    send_req(64'h1000, 8'd3, 16'd5, {3'd4, 2'd1, 4'd0});
    s_axvalid = 1'b0;
    wait_txn(10, c);
    checks++;
    if (c != 1 || txn_size !== 8'd3) begin
      errors++;
      $display("FAIL single_txn: latency=%0d size=%0d expected 1 3", c, txn_size);
    end
    @(negedge clk);
    checks++;
    if (txn_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_txn_pulse: txn_valid=%b in second cycle, expected 0", txn_valid);
    end
    @(posedge clk); #1;
    alc_valid = 1'b1; alc_idx = 4'd2; alc_offset = 10'h40;
    begin
      alc_t a; a.idx = 4'd2; a.off = 10'h40; alc_q.push_back(a);
    end
    @(posedge clk); #1;
    alc_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (desc_wr_en !== 1'b1 || desc_wr_idx !== 4'd2 || desc_wr_addr !== 64'h1000 ||
        desc_wr_len !== 8'd3 || desc_wr_id !== 16'd5 || desc_wr_offset !== 10'h40) begin
      errors++;
      $display("FAIL single_write: wr=%b idx=%0d addr=%0h len=%0d id=%0d off=%0h expected 1 2 1000 3 5 40",
               desc_wr_en, desc_wr_idx, desc_wr_addr, desc_wr_len, desc_wr_id, desc_wr_offset);
    end
    @(negedge clk);
    checks++;
    if (desc_wr_en !== 1'b0 || desc_wr_addr !== 64'h1000 || desc_wr_idx !== 4'd2) begin
      errors++;
      $display("FAIL single_hold: wr=%b addr=%0h idx=%0d expected 0 1000 2", desc_wr_en, desc_wr_addr, desc_wr_idx);
    end
    check_drained("single");
  endtask

  task automatic test_backpressure();
    int c;
    int bad;
    bit hs, ok, wr_seen;
    req_t r3;
    send_req(64'h2000, 8'd1, 16'd1, 9'h011);
    send_req(64'h2100, 8'd2, 16'd2, 9'h022);
    r3.addr = 64'h2200; r3.len = 8'd7; r3.id = 16'd3; r3.attr = 9'h033;
    s_axaddr = r3.addr; s_axlen = r3.len; s_axid = r3.id;
    {s_axsize, s_axburst, s_axsnoop} = r3.attr;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      if (s_axready !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_full: s_axready high in %0d of 6 cycles with 2 queued, expected 0", bad);
    end
    alc_valid = 1'b1; alc_idx = 4'd7; alc_offset = 10'h100;
    begin
      alc_t a; a.idx = 4'd7; a.off = 10'h100; alc_q.push_back(a);
    end
    @(posedge clk); #1;
    alc_valid = 1'b0;
    ok = 1'b0; wr_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (desc_wr_en) wr_seen = 1'b1;
      hs = s_axready;
      @(posedge clk); #1;
      if (hs) begin
        ok = 1'b1;
        break;
      end
    end
    s_axvalid = 1'b0;
    if (ok) exp_q.push_back(r3);
    checks++;
    if (!ok || !wr_seen) begin
      errors++;
      $display("FAIL bp_third_accept: accepted=%b write_before=%b expected 1 1", ok, wr_seen);
    end
    wait_txn(10, c);
    give_alc(4'd8, 10'h110, 1);
    wait_txn(10, c);
    give_alc(4'd9, 10'h120, 3);
    check_drained("bp");
  endtask

  task automatic test_back_to_back();
    int c;
    send_req(64'h3000, 8'd4, 16'h10, 9'h1A5);
    send_req(64'h3040, 8'd5, 16'h11, 9'h05A);
    s_axvalid = 1'b0;
    wait_txn(10, c);
    give_alc(4'd1, 10'h200, 1);
    wait_txn(10, c);
    checks++;
    if (c != 1) begin
      errors++;
      $display("FAIL b2b_spacing: second txn %0d cycles after write, expected 1 (4-cycle period)", c);
    end
    give_alc(4'd3, 10'h210, 1);
    check_drained("b2b");
  endtask

  task automatic test_no_desc();
    int bad;
    int c;
    desc_avail = 16'h0000;
    send_req(64'h4000, 8'd9, 16'h20, 9'h000);
    s_axvalid = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (txn_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL nodesc_hold: txn_valid high %0d times with desc_avail=0, expected 0", bad);
    end
    @(posedge clk); #1;
    desc_avail = 16'h0001;
    @(negedge clk);
    checks++;
    if (txn_valid !== 1'b0) begin
      errors++;
      $display("FAIL nodesc_early: txn_valid=%b in same cycle as desc_avail, expected 0", txn_valid);
    end
    wait_txn(1, c);
    give_alc(4'd0, 10'h300, 2);
    desc_avail = 16'hFFFF;
    check_drained("nodesc");
  endtask

  task automatic test_spurious();
    int bad;
    int c;
    @(posedge clk); #1;
    alc_valid = 1'b1; alc_idx = 4'd5; alc_offset = 10'h3FF;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) alc_valid = 1'b0;
      @(negedge clk);
      if (desc_wr_en !== 1'b0 || txn_valid !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL spurious_alc: %0d cycles with activity after idle alc_valid, expected 0", bad);
    end
    send_req(64'h5000, 8'd0, 16'h30, 9'h0F0);
    s_axvalid = 1'b0;
    wait_txn(10, c);
    checks++;
    if (c != 1) begin
      errors++;
      $display("FAIL spurious_state: txn latency %0d after spurious grant, expected 1", c);
    end
    give_alc(4'd6, 10'h050, 1);
    check_drained("spurious");
  endtask

  task automatic test_reset_mid_wait();
    int c;
    int bad;
    send_req(64'hDEAD0, 8'd12, 16'h40, 9'h111);
    s_axvalid = 1'b0;
    wait_txn(10, c);
    @(posedge clk); #3;
    resetn = 1'b0;
    #1;
    exp_q.delete();
    alc_q.delete();
    checks++;
    if ({s_axready, txn_valid, txn_size, desc_wr_en, desc_wr_idx, desc_wr_addr, desc_wr_len,
         desc_wr_id, desc_wr_attr, desc_wr_offset, alc_timeout} !== '0) begin
      errors++;
      $display("FAIL rst_wait_outputs: txn_size=%0d addr=%0h id=%0h rdy=%b expected all 0",
               txn_size, desc_wr_addr, desc_wr_id, s_axready);
    end
    @(negedge clk); resetn = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (s_axready !== 1'b1) begin
      errors++;
      $display("FAIL rst_wait_ready: s_axready=%b after release, expected 1", s_axready);
    end
    alc_valid = 1'b1; alc_idx = 4'd1; alc_offset = 10'h1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 2) alc_valid = 1'b0;
      @(negedge clk);
      if (desc_wr_en !== 1'b0 || txn_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL rst_wait_stale: %0d cycles of stale activity after reset, expected 0", bad);
    end
  endtask

  task automatic test_timeout();
    int c;
    int bad;
    int found;
    send_req(64'h6000, 8'd6, 16'h50, 9'h0C3);
    s_axvalid = 1'b0;
    wait_txn(10, c);
    bad = 0;
    found = -1;
`ifdef ACE_TXN_REQ_TIMEOUT_EN
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (txn_valid) begin
        found = i;
        break;
      end
      if (alc_timeout !== 1'b0) bad++;
    end
    checks++;
    if (found != 9 || bad != 0 || alc_timeout !== 1'b1) begin
      errors++;
      $display("FAIL timeout_repulse: repulse after %0d cycles, early flags=%0d, flag=%b expected 9 0 1",
               found, bad, alc_timeout);
    end
    give_alc(4'd11, 10'h2A0, 2);
    @(negedge clk);
    checks++;
    if (alc_timeout !== 1'b1) begin
      errors++;
      $display("FAIL timeout_sticky: alc_timeout=%b after write, expected 1", alc_timeout);
    end
`else
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (txn_valid !== 1'b0 || alc_timeout !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL wait_forever: %0d cycles with re-pulse or timeout flag, expected 0", bad);
    end
    give_alc(4'd11, 10'h2A0, 1);
`endif
    check_drained("timeout");
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_no_desc();
    test_spurious();
    test_timeout();
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ace_txn_req_capture.md
Name: ace_txn_req_capture

Overview:
- Upstream stage of the slave-side transaction allocator: accepts AR (or AW) requests from the ACE slave port into a 2-entry request FIFO.
- Issues a single-cycle allocation request (txn_valid/txn_size) and waits for the allocator's alc_valid/alc_idx/alc_offset.
- Then writes the request fields plus the allocated RAM offset into the descriptor register file at alc_idx and pops the FIFO.
- Instantiated once per RD and WR channel.

Parameters:
- ADDR_WIDTH, 64, address width of the captured request.
- DATA_WIDTH, 128, data-RAM word width; used only for the offset width.
- RAM_SIZE, 16384, data RAM bytes; OFFSET_W = CLOG2((RAM_SIZE*8)/DATA_WIDTH).
- MAX_DESC, 16, descriptor count; IDX_W = CLOG2(MAX_DESC).
- ID_WIDTH, 16, AXI ID width.
- TIMEOUT_CYCLES, 1024, allocation timeout limit; used only with the optional feature.

Ports:
- clk  in  1  clock.
- resetn  in  1  reset, asynchronous, active-low.
- s_axvalid  in  1  request valid.
- s_axready  out  1  request ready.
- s_axaddr  in  ADDR_WIDTH  request address.
- s_axlen  in  8  AXLEN.
- s_axid  in  ID_WIDTH  request ID.
- s_axsize  in  3  AXSIZE.
- s_axburst  in  2  AXBURST.
- s_axsnoop  in  4  AxSNOOP; AW zero-extended.
- desc_avail  in  MAX_DESC  free-descriptor bitmap.
- txn_valid  out  1  allocation request pulse.
- txn_size  out  8  AXLEN of the request being allocated.
- alc_valid  in  1  allocation done.
- alc_idx  in  IDX_W  allocated descriptor index.
- alc_offset  in  OFFSET_W  allocated RAM offset.
- desc_wr_en  out  1  descriptor write strobe.
- desc_wr_idx  out  IDX_W  descriptor index.
- desc_wr_addr  out  ADDR_WIDTH  captured address.
- desc_wr_len  out  8  captured AXLEN.
- desc_wr_id  out  ID_WIDTH  captured ID.
- desc_wr_attr  out  9  {size, burst, snoop}.
- desc_wr_offset  out  OFFSET_W  captured RAM offset.
- alc_timeout  out  1  sticky timeout flag; optional feature only.

Behaviour:
- Reset (async assert, sync deassert use):
  - FIFO empty, state IDLE.
  - txn_valid=0, txn_size=0, desc_wr_en=0, all desc_wr_* fields = 0, alc_timeout=0.
  - s_axready=1 once reset is released.
  - Reset mid-allocation abandons the request; no descriptor write is produced.
- FIFO:
  - 2 entries, count register 0..2.
  - s_axready = (count != 2), from registered count only; no pop-to-push bypass when full.
  - Push on s_axvalid & s_axready; pop on the cycle desc_wr_en is driven high.
  - Simultaneous push and pop at count 1: count stays 1, order preserved.
  - Pointers wrap modulo 2.
- FSM states IDLE, ISSUE, WAIT, WRITE:
  - IDLE -> ISSUE when count != 0 and |desc_avail. If desc_avail == 0, hold IDLE.
  - ISSUE: txn_valid=1 for exactly this cycle; txn_size = head.len. Always -> WAIT.
  - WAIT: txn_valid=0. On alc_valid, register alc_idx and alc_offset, -> WRITE. Otherwise hold.
  - alc_valid in IDLE or ISSUE is ignored; no capture occurs.
  - WRITE: desc_wr_en=1 for one cycle.
    - desc_wr_idx / desc_wr_offset = the captured values.
    - Remaining desc_wr_* fields = FIFO head.
    - Pop the FIFO, -> IDLE.
- Latency:
  - Handshake at edge k -> txn_valid high in cycle k+2 at the earliest.
  - alc_valid in cycle m -> desc_wr_en in cycle m+1.
  - Back-to-back requests: one allocation per 4 cycles minimum.
- Only one allocation is outstanding at a time; txn_valid is never reasserted before desc_wr_en.
- desc_wr_* fields hold their last value when desc_wr_en=0.

Optional Feature:
- Macro: ACE_TXN_REQ_TIMEOUT_EN.
- Defined:
  - Counter clears on entering WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES without alc_valid: set alc_timeout (sticky until reset), return to ISSUE and re-pulse txn_valid for the same head entry.
  - alc_valid arriving on the same cycle as expiry wins: go to WRITE, no flag.
- Undefined:
  - No counter; WAIT holds indefinitely.
  - alc_timeout tied to 0.

Test Plan:
- Single request: addr=0x1000, len=3, id=5, desc_avail=0xFFFF; alc_valid 2 cycles after txn_valid with idx=2, offset=0x40 -> txn_valid one cycle with txn_size=3; next cycle desc_wr_en=1, idx=2, addr=0x1000, len=3, id=5, offset=0x40.
- Backpressure: 3 requests back-to-back, alc_valid withheld -> s_axready drops after 2 accepts; third accepted only after the first desc_wr_en; writes occur in id order 1,2,3.
- No descriptors: desc_avail=0 with a request queued for 20 cycles -> txn_valid stays 0; desc_avail=0x0001 -> txn_valid the cycle after next.
- Spurious alc_valid in IDLE with the FIFO empty -> no desc_wr_en; state unchanged.
- Reset mid-WAIT: assert resetn=0 asynchronously -> all outputs 0 immediately, FIFO empty; after release, s_axready=1 and no stale write.
- ACE_TXN_REQ_TIMEOUT_EN with TIMEOUT_CYCLES=8, alc_valid never returned -> alc_timeout=1 after 8 WAIT cycles, txn_valid re-pulsed; alc_valid later -> normal desc_wr_en, flag remains 1.
